// File: rtl/xor_stream_encryptor.sv
// XOR stream encryptor: snapshots the assembled key and XORs each plaintext word with a cycling key segment.
// Optional XOR_KEY_ROTATE_EN: the key rotates left by one bit each time the segment index wraps.
module xor_stream_encryptor #(
  parameter  int DATA_W = 32,
  parameter  int KEY_W  = 512,
  localparam int SEGS   = KEY_W / DATA_W,
  localparam int SEG_W  = $clog2(SEGS)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [KEY_W-1:0]  iAssembled_key,
  input  logic              iCan_encrypt,
  input  logic [DATA_W-1:0] iData,
  input  logic              iData_valid,
  output logic              oData_ready,
  output logic [DATA_W-1:0] oCipher,
  output logic              oCipher_valid,
  input  logic              iCipher_ready,
  output logic [SEG_W-1:0]  oSeg_index,
  output logic [15:0]       oWord_count,
  output logic              oBusy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state, stateNext;
  logic [KEY_W-1:0]   keyReg;
  logic [DATA_W-1:0]  keySeg;
  logic               accept;
  logic               segWrap;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iCan_encrypt) stateNext = LOAD;
      LOAD:    stateNext = RUN;
      RUN:     if (!iCan_encrypt) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output register may reload in the same cycle it is drained.
  assign oData_ready = (state == RUN) && (!oCipher_valid || iCipher_ready);
  assign accept      = iData_valid && oData_ready;
  assign oBusy       = (state == RUN);
  assign keySeg      = keyReg[oSeg_index*DATA_W +: DATA_W];
  assign segWrap     = (oSeg_index == SEG_W'(SEGS-1));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      keyReg        <= '0;
      oCipher       <= '0;
      oCipher_valid <= 1'b0;
      oSeg_index    <= '0;
      oWord_count   <= '0;
    end else begin
      if (state == LOAD) begin
        keyReg      <= iAssembled_key;
        oSeg_index  <= '0;
        oWord_count <= '0;
      end
      if (accept) begin
        oCipher       <= iData ^ keySeg;
        oCipher_valid <= 1'b1;
        oSeg_index    <= segWrap ? '0 : oSeg_index + 1'b1;
        oWord_count   <= oWord_count + 16'd1;
`ifdef XOR_KEY_ROTATE_EN
        if (segWrap) keyReg <= {keyReg[KEY_W-2:0], keyReg[KEY_W-1]};
`endif
      end else if (oCipher_valid && iCipher_ready) begin
        oCipher_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xor_stream_encryptor.sv
// Randomized + directed bench for xor_stream_encryptor against a queue-based reference model.
module tb_xor_stream_encryptor;
  logic         iClk = 1'b0;
  logic         iRst;
  logic [511:0] iAssembled_key;
  logic         iCan_encrypt;
  logic [31:0]  iData;
  logic         iData_valid;
  logic         oData_ready;
  logic [31:0]  oCipher;
  logic         oCipher_valid;
  logic         iCipher_ready;
  logic [3:0]   oSeg_index;
  logic [15:0]  oWord_count;
  logic         oBusy;

  xor_stream_encryptor dut (
    .iClk(iClk), .iRst(iRst), .iAssembled_key(iAssembled_key), .iCan_encrypt(iCan_encrypt),
    .iData(iData), .iData_valid(iData_valid), .oData_ready(oData_ready),
    .oCipher(oCipher), .oCipher_valid(oCipher_valid), .iCipher_ready(iCipher_ready),
    .oSeg_index(oSeg_index), .oWord_count(oWord_count), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;

  // reference model
  bit           mRun, mLoad;
  logic [511:0] mKey;
  int           mSeg, mCnt;
  logic [31:0]  q[$];
  logic [31:0]  lastOut;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    mRun = 0; mLoad = 0; mKey = '0; mSeg = 0; mCnt = 0; q.delete();
  endtask

  function automatic logic [511:0] patKey(input logic [31:0] base);
    logic [511:0] k;
    for (int s = 0; s < 16; s++) k[s*32 +: 32] = base | 32'(s);
    return k;
  endfunction

  function automatic logic [511:0] rndKey();
    logic [511:0] k;
    for (int s = 0; s < 16; s++) k[s*32 +: 32] = $urandom;
    return k;
  endfunction

  // One clock: check visible state mid-cycle, then advance the model at the edge.
  task automatic cyc();
    bit rdy, fire, acc;
    @(negedge iClk);
    rdy  = mRun && (q.size() == 0 || iCipher_ready);
    fire = (q.size() != 0) && iCipher_ready;
    acc  = iData_valid && rdy;
    chk("ready", oData_ready, rdy);
    chk("valid", oCipher_valid, q.size() != 0);
    if (q.size() != 0) chk("cipher", oCipher, q[0]);
    chk("seg", oSeg_index, mSeg);
    chk("count", oWord_count, mCnt);
    chk("busy", oBusy, mRun);
    @(posedge iClk);
    if (fire) lastOut = q.pop_front();
    if (acc) begin
      q.push_back(iData ^ mKey[mSeg*32 +: 32]);
      mCnt = (mCnt + 1) % 65536;
      if (mSeg == 15) begin
        mSeg = 0;
`ifdef XOR_KEY_ROTATE_EN
        mKey = {mKey[510:0], mKey[511]};
`endif
      end else mSeg++;
    end
    if (mRun && !iCan_encrypt) mRun = 0;
    else if (mLoad) begin
      mKey = iAssembled_key; mSeg = 0; mCnt = 0; mLoad = 0; mRun = 1;
    end else if (!mRun && iCan_encrypt) mLoad = 1;
    #1;
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_cipher"}, oCipher, 0);
    chk({tag, "_valid"}, oCipher_valid, 0);
    chk({tag, "_seg"}, oSeg_index, 0);
    chk({tag, "_count"}, oWord_count, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_ready"}, oData_ready, 0);
  endtask

  initial begin
    iRst = 1'b0; iAssembled_key = '0; iCan_encrypt = 0; iData = '0;
    iData_valid = 0; iCipher_ready = 1; lastOut = '0;
    modelReset();
    repeat (3) @(posedge iClk);
    #1 chkZero("rst");
    iRst = 1'b1;

    // 16 zero words against the pattern key, then one all-ones word
    iAssembled_key = patKey(32'hA5A5_0000);
    iCan_encrypt = 1;
    repeat (2) cyc();
    iData_valid = 1; iData = 32'h0;
    repeat (16) cyc();
    chk("cnt16", oWord_count, 16);
    chk("seg16", oSeg_index, 0);
    iData = 32'hFFFF_FFFF;
    cyc();
    iData_valid = 0;
    cyc();
`ifdef XOR_KEY_ROTATE_EN
    chk("word17", lastOut, 32'hB4B5_FFFE);
`else
    chk("word17", lastOut, 32'h5A5A_FFFF);
`endif

    // backpressure for 3 cycles, key changes meanwhile must be ignored
    iData_valid = 1; iData = $urandom; cyc();
    iCipher_ready = 0; iAssembled_key = rndKey();
    repeat (3) begin iData = $urandom; cyc(); end
    iCipher_ready = 1;
    repeat (4) begin iData = $urandom; cyc(); end

    // randomized traffic with occasional key churn and re-keys
    for (int i = 0; i < 400; i++) begin
      iData         = $urandom;
      iData_valid   = ($urandom_range(0, 3) != 0);
      iCipher_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) iAssembled_key = rndKey();
      if ($urandom_range(0, 39) == 0) iCan_encrypt = ~iCan_encrypt;
      cyc();
    end

    // drop the enable with a word pending, then re-key
    iCan_encrypt = 1; iCipher_ready = 1; iData_valid = 0;
    repeat (4) cyc();
    iData_valid = 1; iData = $urandom; cyc();
    iCipher_ready = 0; cyc();
    iCan_encrypt = 0; cyc();
    iCipher_ready = 1; repeat (2) cyc();
    chk("idle_busy", oBusy, 0);
    iData_valid = 0;
    iAssembled_key = rndKey();
    iAssembled_key[31:0] = 32'h1234_5678;
    iCan_encrypt = 1;
    repeat (2) cyc();
    iData_valid = 1; iData = 32'h0; cyc();
    iData_valid = 0; cyc();
    chk("rekey", lastOut, 32'h1234_5678);
    chk("rekey_cnt", oWord_count, 1);

    // asynchronous reset with a stalled word in the output register
    iData_valid = 1; iData = $urandom; iCipher_ready = 0;
    repeat (2) cyc();
    chk("pre_rst_valid", oCipher_valid, 1);
    @(negedge iClk);
    #2 iRst = 1'b0;
    #1 chkZero("async");
    modelReset();
    iData_valid = 0; iCan_encrypt = 0; iCipher_ready = 1;
    @(posedge iClk); #1 iRst = 1'b1;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
